// File: rtl/instruction_decoder_if.sv
// Program-memory / decode bus between the program sequencer and the decode stage.
// There is no handshake on this bus: every signal is sampled or produced each
// cycle. pm_data is taken into IR on every rising clock edge unconditionally,
// and the decode outputs are combinational from IR, valid for the whole cycle.
interface instruction_decoder_if;
  logic [7:0] pm_data;
  logic       dont_jmp;
  logic [1:0] dbg_sel;
  logic       sync_reset;
  logic       jmp;
  logic       jmp_nz;
  logic [3:0] jmp_addr;
  logic       load_instr;
  logic       NOPC8;
  logic [7:0] reg_en;
  logic [3:0] src_sel;
  logic       alu_en;
  logic [4:0] alu_func;
  logic [7:0] from_ID;

  // Sequencer side: supplies the instruction word, zero flag and debug select.
  modport master (
    output pm_data, dont_jmp, dbg_sel,
    input  sync_reset, jmp, jmp_nz, jmp_addr, load_instr, NOPC8,
           reg_en, src_sel, alu_en, alu_func, from_ID
  );

  // Decode-stage side.
  modport slave (
    input  pm_data, dont_jmp, dbg_sel,
    output sync_reset, jmp, jmp_nz, jmp_addr, load_instr, NOPC8,
           reg_en, src_sel, alu_en, alu_func, from_ID
  );
endinterface

// File: rtl/instruction_decoder.sv
// Decode stage of the 8-bit microprocessor: instruction register, combinational
// decode into jump / register-write / ALU controls, registered sync_reset and
// debug counters readable through from_ID.
module instruction_decoder (
  input  logic                   clk,
  input  logic                   reset,
  instruction_decoder_if.slave   bus
);

  // NOPC8 encoding: decodes to no write and no jump.
  localparam logic [7:0] IR_RESET = 8'hC8;

  logic [7:0] ir;
  logic       sync_reset_q;
  logic [7:0] instr_count;
  logic [7:0] taken_count;
  logic [7:0] nop_count;

  logic       jmp;
  logic       jmp_nz;
  logic [3:0] jmp_addr;
  logic       load_instr;
  logic       nopc8;
  logic [7:0] reg_en;
  logic [3:0] src_sel;
  logic       alu_en;
  logic [4:0] alu_func;
  logic       taken;

  // Instruction register loads every edge, even under sync_reset, so mem[0]
  // is already in IR on the first cycle after sync_reset drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ir <= IR_RESET;
    else       ir <= bus.pm_data;
  end

  // Registered reset: set asynchronously, cleared on the first edge after release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_reset_q <= 1'b1;
    else       sync_reset_q <= 1'b0;
  end

  // Decode of IR; everything is held at zero while sync_reset is high.
  always_comb begin
    jmp        = 1'b0;
    jmp_nz     = 1'b0;
    jmp_addr   = 4'h0;
    load_instr = 1'b0;
    nopc8      = 1'b0;
    reg_en     = 8'h00;
    src_sel    = 4'h0;
    alu_en     = 1'b0;
    alu_func   = 5'h00;
    if (!sync_reset_q) begin
      jmp_addr = ir[3:0];
      casez (ir)
        8'b0???_????: begin
          load_instr = 1'b1;
          reg_en     = 8'd1 << ir[6:4];
          src_sel    = 4'd8;
        end
        8'b10??_????: begin
          src_sel = {1'b0, ir[2:0]};
          // A move onto itself is suppressed entirely.
          if (ir[5:3] != ir[2:0]) reg_en = 8'd1 << ir[5:3];
        end
        8'b110?_????: begin
          if (ir == IR_RESET) begin
            nopc8 = 1'b1;
          end else begin
            alu_en   = 1'b1;
            alu_func = ir[4:0];
          end
        end
        8'b1110_????: jmp    = 1'b1;
        default:      jmp_nz = 1'b1;
      endcase
    end
  end

  // jmp_nz is reported raw; the zero flag only qualifies the taken count.
  assign taken = jmp | (jmp_nz & ~bus.dont_jmp);

  // Debug counters: cleared by reset, held at zero during sync_reset, wrap at 8 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_count <= 8'h00;
      taken_count <= 8'h00;
      nop_count   <= 8'h00;
    end else if (sync_reset_q) begin
      instr_count <= 8'h00;
      taken_count <= 8'h00;
      nop_count   <= 8'h00;
    end else begin
      instr_count <= instr_count + 8'd1;
      if (taken) taken_count <= taken_count + 8'd1;
      if (nopc8) nop_count   <= nop_count + 8'd1;
    end
  end

  // Debug read-back select.
  always_comb begin
    case (bus.dbg_sel)
      2'd0:    bus.from_ID = ir;
      2'd1:    bus.from_ID = instr_count;
      2'd2:    bus.from_ID = taken_count;
      default: bus.from_ID = nop_count;
    endcase
  end

  assign bus.sync_reset = sync_reset_q;
  assign bus.jmp        = jmp;
  assign bus.jmp_nz     = jmp_nz;
  assign bus.jmp_addr   = jmp_addr;
  assign bus.load_instr = load_instr;
  assign bus.NOPC8      = nopc8;
  assign bus.reg_en     = reg_en;
  assign bus.src_sel    = src_sel;
  assign bus.alu_en     = alu_en;
  assign bus.alu_func   = alu_func;

endmodule
